// File: rtl/amc_demod_engine.sv
// Multi-mode hard-decision I/Q demodulator (BPSK/QPSK/8PSK/16QAM) with an output FIFO.
// Optional symbol counter port sym_count is enabled by defining AMC_DEMOD_SYMCNT_EN.
module amc_demod_engine #(
    parameter int IQ_W       = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int QAM_THR    = 2**(IQ_W-2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IQ_W-1:0] i_in,
    input  logic signed [IQ_W-1:0] q_in,
    input  logic [1:0]             mode_req,
    output logic [1:0]             mode_act,
    output logic                   mode_switched,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             bit_out,
    output logic [1:0]             out_mode
`ifdef AMC_DEMOD_SYMCNT_EN
    ,
    output logic [15:0]            sym_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [IQ_W-1:0] MOST_NEG  = {1'b1, {(IQ_W-1){1'b0}}};
    localparam logic [IQ_W-1:0] MAX_POS   = {1'b0, {(IQ_W-1){1'b1}}};
    localparam logic [IQ_W-1:0] THR       = IQ_W'(QAM_THR);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_t;

    state_t state_reg, state_next;

    logic [1:0]    mode_act_reg;
    logic          mode_switched_reg;
    logic          slice_valid_reg;
    logic [3:0]    slice_bits_reg;
    logic [1:0]    slice_mode_reg;
    logic [3:0]    slice_bits_next;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW:0]   credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic [IQ_W-1:0] abs_i;
    logic [IQ_W-1:0] abs_q;
    logic          sign_i;
    logic          sign_q;

    // Magnitude saturates so the most-negative code maps to the largest positive one.
    function automatic logic [IQ_W-1:0] sat_abs(input logic [IQ_W-1:0] x);
        if (x == MOST_NEG)
            return MAX_POS;
        else if (x[IQ_W-1])
            return ~x + 1'b1;
        else
            return x;
    endfunction

    assign sign_i = i_in[IQ_W-1];
    assign sign_q = q_in[IQ_W-1];
    assign abs_i  = sat_abs(i_in);
    assign abs_q  = sat_abs(q_in);

    always_comb begin
        slice_bits_next = '0;
        case (mode_act_reg)
            2'b00:   slice_bits_next = {3'b000, sign_i};
            2'b01:   slice_bits_next = {2'b00, sign_i, sign_q};
            2'b10:   slice_bits_next = {1'b0, sign_i, sign_q, (abs_i < abs_q)};
            default: slice_bits_next = {sign_i, (abs_i < THR), sign_q, (abs_q < THR)};
        endcase
    end

    // Credit covers both the FIFO and the symbol sitting in the slice stage.
    assign credit   = {1'b0, count_reg} + {{CW{1'b0}}, slice_valid_reg};
    assign in_ready = rst_n && (state_reg == ST_RUN) && (credit < {1'b0, DEPTH_CNT});
    assign accept   = in_valid && in_ready;

    assign fifo_full = (count_reg == DEPTH_CNT);
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign push      = slice_valid_reg && (!fifo_full || pop);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (mode_req != mode_act_reg) state_next = ST_DRAIN;
            ST_DRAIN:  if (!slice_valid_reg && (count_reg == '0)) state_next = ST_SWITCH;
            ST_SWITCH: state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_RUN;
            mode_act_reg      <= 2'b00;
            mode_switched_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            mode_switched_reg <= (state_reg == ST_SWITCH) && (mode_req != mode_act_reg);
            if (state_reg == ST_SWITCH)
                mode_act_reg <= mode_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_valid_reg <= 1'b0;
            slice_bits_reg  <= '0;
            slice_mode_reg  <= '0;
        end else begin
            slice_valid_reg <= accept;
            if (accept) begin
                slice_bits_reg <= slice_bits_next;
                slice_mode_reg <= mode_act_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {slice_mode_reg, slice_bits_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bit_out       = out_valid ? mem[rd_ptr_reg][3:0] : 4'b0000;
    assign out_mode      = out_valid ? mem[rd_ptr_reg][5:4] : 2'b00;
    assign mode_act      = mode_act_reg;
    assign mode_switched = mode_switched_reg;

`ifdef AMC_DEMOD_SYMCNT_EN
    logic [15:0] sym_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sym_count_reg <= '0;
        else if (state_reg == ST_SWITCH)
            sym_count_reg <= '0;
        else if (pop && (sym_count_reg != 16'hFFFF))
            sym_count_reg <= sym_count_reg + 16'd1;
    end

    assign sym_count = sym_count_reg;
`endif

endmodule

// File: tb/tb_amc_demod_engine.sv
// Directed bench for amc_demod_engine: a slicing model feeds a scoreboard queue on accept,
// and outputs are popped and compared as they leave the FIFO.
module tb_amc_demod_engine;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [4:0] i_in;
    logic signed [4:0] q_in;
    logic [1:0]        mode_req;
    logic [1:0]        mode_act;
    logic              mode_switched;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        bit_out;
    logic [1:0]        out_mode;
`ifdef AMC_DEMOD_SYMCNT_EN
    logic [15:0]       sym_count;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [1:0] exp_mode = 2'b00;
    logic [5:0] sb [$];

    amc_demod_engine #(.IQ_W(5), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .i_in          (i_in),
        .q_in          (q_in),
        .mode_req      (mode_req),
        .mode_act      (mode_act),
        .mode_switched (mode_switched),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .bit_out       (bit_out),
        .out_mode      (out_mode)
`ifdef AMC_DEMOD_SYMCNT_EN
        ,
        .sym_count     (sym_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference slicer, written from the constellation definitions (IQ_W=5, threshold 8).
    function automatic logic [3:0] model(input logic [1:0] m, input int i, input int q);
        int ai;
        int aq;
        logic si;
        logic sq;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > 15) ai = 15;
        if (aq > 15) aq = 15;
        si = (i < 0);
        sq = (q < 0);
        case (m)
            2'b00:   return {3'b000, si};
            2'b01:   return {2'b00, si, sq};
            2'b10:   return {1'b0, si, sq, (ai < aq)};
            default: return {si, (ai < 8), sq, (aq < 8)};
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            sb.push_back({exp_mode, model(exp_mode, int'(i_in), int'(q_in))});
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", int'(out_valid), 0);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                check("bit_out", int'(bit_out), int'(e[3:0]));
                check("out_mode", int'(out_mode), int'(e[5:4]));
                pops++;
                $display("txn %0d: bits=%b mode=%0d (exp bits=%b mode=%0d)",
                         pops, bit_out, out_mode, e[3:0], e[5:4]);
            end
        end
    end

    task automatic send(input int i, input int q);
        bit ok;
        i_in     = 5'(i);
        q_in     = 5'(q);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_in_time", int'(ok), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_check(input string tag, input logic [3:0] bits, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, int'(ok), 1);
        check({tag, "_bits"}, int'(bit_out), int'(bits));
        check({tag, "_mode"}, int'(out_mode), int'(m));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_switch(input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mode_switched) begin
                ok = 1'b1;
                break;
            end
        end
        check("switch_seen", int'(ok), 1);
        check("mode_act_new", int'(mode_act), int'(m));
        exp_mode = m;
        @(negedge clk);
        check("switch_pulse_1cyc", int'(mode_switched), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic change_mode(input logic [1:0] m);
        mode_req = m;
        wait_switch(m);
    endtask

    initial begin
        int pops_base;
        bit ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        i_in      = '0;
        q_in      = '0;
        mode_req  = 2'b00;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_mode_act", int'(mode_act), 0);
        check("rst_mode_switched", int'(mode_switched), 0);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_out_mode", int'(out_mode), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // BPSK, two-cycle latency
        send(-3, 5);
        @(negedge clk);
        check("lat_cycle1_out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle2_out_valid", int'(out_valid), 1);
        check("bpsk_bits", int'(bit_out), 4'b0001);
        check("bpsk_mode", int'(out_mode), 0);
        @(posedge clk);
        #1;

        // 16QAM
        change_mode(2'b11);
        send(9, -2);
        wait_out_check("qam_a", 4'b0011, 2'b11);
        send(-16, 7);
        wait_out_check("qam_b", 4'b1001, 2'b11);

        // 8PSK
        change_mode(2'b10);
        send(2, -6);
        wait_out_check("psk8_a", 4'b0011, 2'b10);
        send(-7, 1);
        wait_out_check("psk8_b", 4'b0100, 2'b10);

        // QPSK backpressure: exactly four credits
        change_mode(2'b01);
        pops_base = pops;
        out_ready = 1'b0;
        send(3, 4);
        send(-3, 4);
        send(3, -4);
        send(-3, -4);
        i_in     = 5'sd1;
        q_in     = -5'sd1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", int'(in_ready), 0);
            check("full_sb_size", sb.size(), 4);
            check("full_out_valid", int'(out_valid), 1);
            check("hold_bits", int'(bit_out), int'(sb[0][3:0]));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(1, -1);
        send(-1, 1);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stream_drained", int'(ok), 1);
        check("stream_pop_count", pops - pops_base, 6);
`ifdef AMC_DEMOD_SYMCNT_EN
        check("sym_count_6", int'(sym_count), 6);
`endif
        @(posedge clk);
        #1;

        // Mode change with three symbols held in the FIFO
        out_ready = 1'b0;
        send(5, 6);
        send(-5, 6);
        send(5, -6);
        mode_req = 2'b00;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check("drain_in_ready", int'(in_ready), 0);
            check("drain_mode_act", int'(mode_act), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        pops_base = pops;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mode_switched) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_switch_seen", int'(ok), 1);
        check("drained_before_switch", pops - pops_base, 3);
        check("drain_mode_act_new", int'(mode_act), 0);
        exp_mode = 2'b00;
        @(negedge clk);
        check("drain_pulse_1cyc", int'(mode_switched), 0);
        @(posedge clk);
        #1;
        send(5, -2);
        wait_out_check("post_switch", 4'b0000, 2'b00);

        // Reset with a full FIFO
        change_mode(2'b11);
        out_ready = 1'b0;
        send(1, 1);
        send(-1, 1);
        send(1, -1);
        send(-1, -1);
        rst_n    = 1'b0;
        mode_req = 2'b00;
        exp_mode = 2'b00;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_mode_act", int'(mode_act), 0);
        check("midrst_in_ready", int'(in_ready), 0);
`ifdef AMC_DEMOD_SYMCNT_EN
        check("midrst_sym_count", int'(sym_count), 0);
`endif
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(-1, 2);
        wait_out_check("postrst", 4'b0001, 2'b00);
        repeat (3) @(posedge clk);
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/amc_demod_engine.md
Name: amc_demod_engine

Overview:
Parametrised multi-mode hard-decision demodulator for the AMC receive path. It accepts signed I/Q samples through a valid/ready handshake and slices each sample into BPSK, QPSK, 8-PSK or 16-QAM bits according to the active mode. Results are buffered in an output FIFO. A requested mode change takes effect only after the pipeline has drained, so every symbol is sliced and tagged with exactly one mode.

Parameters:
IQ_W, 5, signed two's-complement width of i_in/q_in (min 3)
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
QAM_THR, 2**(IQ_W-2), 16-QAM inner/outer amplitude threshold (default 8 at IQ_W=5)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample valid
in_ready  out  1  block can accept a sample this cycle
i_in  in  IQ_W  signed in-phase sample
q_in  in  IQ_W  signed quadrature sample
mode_req  in  2  requested mode: 00 BPSK, 01 QPSK, 10 8PSK, 11 16QAM
mode_act  out  2  mode currently applied
mode_switched  out  1  one-cycle pulse when mode_act changes
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
bit_out  out  4  sliced bits, zero-extended (BPSK 000b, QPSK 00bb, 8PSK 0bbb, QAM bbbb)
out_mode  out  2  mode used to slice the head symbol

Behaviour:
- Reset (async assert, sync release) values: in_ready=0 in the cycle reset is held, FSM=RUN, mode_act=00, mode_switched=0, FIFO empty, out_valid=0, bit_out=0, out_mode=0, slice stage empty.
- Accept: an input is accepted when in_valid && in_ready. The sample is registered into the slice stage (1 cycle), then written to the FIFO. Latency from accept to out_valid is 2 cycles when the FIFO is empty.
- in_ready = (FSM==RUN) && (fifo_count + slice_stage_full < FIFO_DEPTH). Credit counting guarantees no overflow; no sample is ever dropped.
- Slicing (s = sign bit, |x| saturates at the most-negative value):
  - BPSK: b0=s(I).
  - QPSK: {s(I),s(Q)}.
  - 8PSK: {s(I),s(Q),(|I|<|Q|)}.
  - 16QAM: {s(I),|I|<QAM_THR,s(Q),|Q|<QAM_THR}.
- FIFO read: the head is popped when out_valid && out_ready. Simultaneous push and pop while full is allowed and the count is unchanged. Popping while empty is ignored.
- FSM:
  - RUN: if mode_req != mode_act, go to DRAIN and drop in_ready the next cycle. The sample accepted in the transition cycle is sliced in the old mode.
  - DRAIN: wait until the slice stage is empty and the FIFO is empty, then go to SWITCH.
  - SWITCH (1 cycle): mode_act <= mode_req sampled this cycle, pulse mode_switched, return to RUN.
  - If mode_req returns to mode_act during DRAIN, the drain still completes, and SWITCH pulses only if the value differs. Otherwise return to RUN silently.
- mode_req changes during RUN are evaluated every cycle. No synchroniser is required; the input is same-domain.
- Reset mid-operation clears the FIFO and slice stage, forces mode_act=00 and discards all in-flight symbols.
- out_mode/bit_out are stable while out_valid && !out_ready.

Optional Feature:
Macro AMC_DEMOD_SYMCNT_EN.
- Defined: adds output sym_count[15:0]. It increments on each FIFO pop, saturates at 16'hFFFF, clears on reset and in the SWITCH cycle.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, then mode_req=00, push I=-3 Q=+5 with out_ready=1 -> out_valid 2 cycles after accept, bit_out=0001, out_mode=00.
- mode_req=11 -> DRAIN, SWITCH, mode_switched pulse, mode_act=11. Push (I=+9,Q=-2) -> bit_out=0011. Push (I=-16,Q=+7) -> bit_out=1001.
- mode_req=10, push (I=+2,Q=-6) -> bit_out=0011. Push (I=-7,Q=+1) -> bit_out=0100.
- out_ready=0, stream 6 samples in QPSK -> in_ready drops after 4 accepts. Raise out_ready -> all 6 symbols emerge in order, none lost or duplicated.
- With FIFO holding 3 QPSK symbols, change mode_req to 00 -> in_ready=0 until the 3 symbols drain, then a 1-cycle mode_switched. The next symbol has out_mode=00.
- Assert rst_n=0 mid-stream with a full FIFO -> out_valid=0 immediately, mode_act=00. With AMC_DEMOD_SYMCNT_EN defined, sym_count=0.
